// File: rtl/freq_meter_pkg.sv
// Shared types, default constants and helpers for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam int unsigned DEF_GATE_CYCLES = 25_000_000;
    localparam int unsigned DEF_GW          = 25;

    // Increment that sticks at max_value; callers zero-extend operands up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector (one-cycle pulse per rise).
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic sync_a;
    logic sync_b;
    logic sync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_a <= d;
            sync_b <= sync_a;
            sync_d <= sync_b;
        end
    end

    assign q    = sync_b;
    assign rise = sync_b & ~sync_d;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clk cycles.
// Optional period measurement between edges when FREQ_METER_PERIOD_MEAS_EN is defined.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned GW          = DEF_GW,
    parameter int unsigned CW          = 16
`ifdef FREQ_METER_PERIOD_MEAS_EN
    ,
    parameter int unsigned PW          = 26
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sig_in,
    output logic [CW-1:0] count,
    output logic          valid,
    output logic          overflow,
    output logic          busy
`ifdef FREQ_METER_PERIOD_MEAS_EN
    ,
    output logic [PW-1:0] period,
    output logic          period_valid
`endif
);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] EDGE_MAX  = '1;

    state_t        state;
    logic [GW-1:0] gate_cnt;
    logic [CW-1:0] edge_cnt;
    logic          sat;
    logic          edge_pulse;
    logic          sync_level_unused;
    logic [CW-1:0] edge_next;
    logic          edge_at_max;

    sync_edge_det u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .q     (sync_level_unused),
        .rise  (edge_pulse)
    );

    always_comb begin
        edge_at_max = (edge_cnt == EDGE_MAX);
        edge_next   = CW'(sat_inc(32'(edge_cnt), 32'(EDGE_MAX)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= MEASURE;
                        busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        // An edge on the terminal cycle still belongs to the closing window.
                        count    <= edge_pulse ? edge_next : edge_cnt;
                        overflow <= sat | (edge_pulse & edge_at_max);
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        if (!en) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        if (edge_pulse) begin
                            edge_cnt <= edge_next;
                            if (edge_at_max)
                                sat <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_MEAS_EN
    localparam logic [PW-1:0] PERIOD_MAX = '1;

    logic [PW-1:0] period_cnt;
    logic          armed;

    // First edge after entering MEASURE only arms the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt   <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (state != MEASURE) begin
                period_cnt <= '0;
                armed      <= 1'b0;
            end else if (edge_pulse) begin
                if (armed) begin
                    period       <= period_cnt;
                    period_valid <= 1'b1;
                end
                period_cnt <= PW'(1);
                armed      <= 1'b1;
            end else if (armed) begin
                period_cnt <= PW'(sat_inc(32'(period_cnt), 32'(PERIOD_MAX)));
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter with a 100-cycle gate and 4-bit count.
module tb_freq_meter;

    localparam int unsigned GATE = 100;
    localparam int unsigned GW   = 7;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] count;
    logic          valid;
    logic          overflow;
    logic          busy;
`ifdef FREQ_METER_PERIOD_MEAS_EN
    logic [25:0]   period;
    logic          period_valid;
`endif

    int   sig_period = 0;
    logic sig_manual = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    freq_meter #(
        .GATE_CYCLES (GATE),
        .GW          (GW),
        .CW          (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sig_in   (sig_in),
        .count    (count),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
`ifdef FREQ_METER_PERIOD_MEAS_EN
        ,
        .period       (period),
        .period_valid (period_valid)
`endif
    );

    // sig_in source: square wave of sig_period clk cycles, or sig_manual when sig_period is 0.
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (sig_period == 0) begin
                sig_in = sig_manual;
                ph = 0;
            end else begin
                if (ph >= sig_period - 1) ph = 0;
                else ph = ph + 1;
                sig_in = (ph < sig_period / 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        idle(2);
        n_cmp++; if (count !== '0)    begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
`ifdef FREQ_METER_PERIOD_MEAS_EN
        n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_period_valid: got %0b expected 0", period_valid); end
        n_cmp++; if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
`endif
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_continuous();
        sig_period = 10;
        idle(20);
        en = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy_entry: got %0b expected 1", busy); end
        for (int k = 1; k <= 300; k++) begin
            tick();
            n_cmp++; if (valid !== (k % 100 == 0)) begin n_fail++; $display("FAIL cont_valid@%0d: got %0b expected %0b", k, valid, (k % 100 == 0)); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy@%0d: got %0b expected 1", k, busy); end
            if (k % 100 == 0) begin
                n_cmp++; if (count !== 4'(10)) begin n_fail++; $display("FAIL cont_count@%0d: got %0d expected 10", k, count); end
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL cont_overflow@%0d: got %0b expected 0", k, overflow); end
            end
        end
        en = 1'b0;
        idle(5);
    endtask

    task automatic test_saturation();
        sig_period = 2;
        idle(20);
        en = 1'b1;
        tick();
        for (int k = 1; k <= 300; k++) begin
            tick();
            n_cmp++; if (valid !== (k % 100 == 0)) begin n_fail++; $display("FAIL sat_valid@%0d: got %0b expected %0b", k, valid, (k % 100 == 0)); end
            if (k == 100) begin
                n_cmp++; if (count !== 4'(15)) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", count); end
                n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %0b expected 1", overflow); end
                sig_period = 20;
            end
            if (k == 150) begin
                n_cmp++; if (count !== 4'(15)) begin n_fail++; $display("FAIL sat_count_hold: got %0d expected 15", count); end
            end
            if (k == 300) begin
                n_cmp++; if (count !== 4'(5)) begin n_fail++; $display("FAIL slow_count: got %0d expected 5", count); end
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL slow_overflow: got %0b expected 0", overflow); end
            end
        end
        en = 1'b0;
        idle(5);
    endtask

    task automatic test_en_drop();
        sig_period = 10;
        idle(20);
        en = 1'b1;
        tick();
        for (int k = 1; k <= 150; k++) begin
            tick();
            n_cmp++; if (valid !== (k == 100)) begin n_fail++; $display("FAIL drop_valid@%0d: got %0b expected %0b", k, valid, (k == 100)); end
            if (k == 100) begin
                n_cmp++; if (count !== 4'(10)) begin n_fail++; $display("FAIL drop_first_count: got %0d expected 10", count); end
            end
        end
        en = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %0b expected 0", busy); end
        sig_period = 20;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle_valid@%0d: got %0b expected 0", i, valid); end
            n_cmp++; if (count !== 4'(10)) begin n_fail++; $display("FAIL drop_idle_count@%0d: got %0d expected 10", i, count); end
        end
        en = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL redo_busy: got %0b expected 1", busy); end
        for (int q = 1; q <= 100; q++) begin
            tick();
            n_cmp++; if (valid !== (q == 100)) begin n_fail++; $display("FAIL redo_valid@%0d: got %0b expected %0b", q, valid, (q == 100)); end
            n_cmp++; if (count !== ((q == 100) ? 4'(5) : 4'(10))) begin n_fail++; $display("FAIL redo_count@%0d: got %0d expected %0d", q, count, (q == 100) ? 5 : 10); end
        end
        en = 1'b0;
        idle(5);
    endtask

    task automatic test_edge_boundary();
        sig_period = 0;
        sig_manual = 1'b0;
        idle(10);
        en = 1'b1;
        tick();
        for (int k = 1; k <= 300; k++) begin
            tick();
            n_cmp++; if (valid !== (k % 100 == 0)) begin n_fail++; $display("FAIL bnd_valid@%0d: got %0b expected %0b", k, valid, (k % 100 == 0)); end
            if (k % 100 == 0) begin
                n_cmp++; if (count !== ((k == 200) ? 4'(0) : 4'(1))) begin n_fail++; $display("FAIL bnd_count@%0d: got %0d expected %0d", k, count, (k == 200) ? 0 : 1); end
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bnd_overflow@%0d: got %0b expected 0", k, overflow); end
            end
            // Rise at 97 lands on gate_cnt 99; rise at 198 lands on gate_cnt 0 of window three.
            if (k == 97)  sig_manual = 1'b1;
            if (k == 120) sig_manual = 1'b0;
            if (k == 198) sig_manual = 1'b1;
            if (k == 230) sig_manual = 1'b0;
        end
        en = 1'b0;
        idle(5);
    endtask

    task automatic test_reset_mid();
        sig_period = 10;
        idle(20);
        en = 1'b1;
        tick();
        for (int k = 1; k <= 170; k++) begin
            tick();
            n_cmp++; if (valid !== (k == 100)) begin n_fail++; $display("FAIL rst_pre_valid@%0d: got %0b expected %0b", k, valid, (k == 100)); end
            if (k == 100) begin
                n_cmp++; if (count !== 4'(10)) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 10", count); end
            end
        end
        reset = 1'b1;
        sig_period = 0;
        sig_manual = 1'b0;
        #1;
        n_cmp++; if (count !== '0)      begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        n_cmp++; if (valid !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_valid: got %0b expected 0", valid); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow: got %0b expected 0", overflow); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_resume_busy: got %0b expected 1", busy); end
        sig_period = 10;
        for (int r = 1; r <= 100; r++) begin
            tick();
            n_cmp++; if (valid !== (r == 100)) begin n_fail++; $display("FAIL rst_post_valid@%0d: got %0b expected %0b", r, valid, (r == 100)); end
            n_cmp++; if (count !== ((r == 100) ? 4'(10) : 4'(0))) begin n_fail++; $display("FAIL rst_post_count@%0d: got %0d expected %0d", r, count, (r == 100) ? 10 : 0); end
        end
        en = 1'b0;
        idle(5);
    endtask

`ifdef FREQ_METER_PERIOD_MEAS_EN
    task automatic test_period();
        int last_pv;
        int npv;
        last_pv = 0;
        npv = 0;
        sig_period = 37;
        idle(80);
        en = 1'b1;
        tick();
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k <= 37) begin
                n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL per_arm@%0d: got %0b expected 0", k, period_valid); end
            end else if (period_valid === 1'b1) begin
                n_cmp++; if (period !== 26'(37)) begin n_fail++; $display("FAIL per_value@%0d: got %0d expected 37", k, period); end
                if (last_pv != 0) begin
                    n_cmp++; if (k - last_pv != 37) begin n_fail++; $display("FAIL per_spacing@%0d: got %0d expected 37", k, k - last_pv); end
                end
                last_pv = k;
                npv++;
            end
        end
        n_cmp++; if (npv < 5) begin n_fail++; $display("FAIL per_pulses: got %0d expected at least 5", npv); end
        en = 1'b0;
        idle(5);
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_saturation();
        test_en_drop();
        test_edge_boundary();
        test_reset_mid();
`ifdef FREQ_METER_PERIOD_MEAS_EN
        test_period();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter: counts rising edges of an asynchronous input `sig_in` over a fixed window of GATE_CYCLES `clk` cycles.
- At the end of each window it reports the edge count with a one-cycle `valid` pulse.
- It is the measuring end of the team's clock-divider outputs. It is used on the board to check divided clocks (e.g. a 2 Hz tick on a 25 MHz clock) and to display external signal frequency on the 7-segment driver.
- Windows run back to back while `en` is high.

Parameters:
- GATE_CYCLES, default 25000000: window length in clk cycles (1 s at 25 MHz); must be ≥ 2.
- GW, default 25: gate counter width; must satisfy 2^GW ≥ GATE_CYCLES.
- CW, default 16: edge count width; the count saturates at 2^CW-1.
- PW, default 26: period counter width; used only with PERIOD_MEAS_EN.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset, asynchronous, active-high.
- en, input, 1: synchronous to clk; 1 = measure continuously, 0 = idle.
- sig_in, input, 1: signal under test, asynchronous to clk.
- count, output, CW: edge count of the last completed window.
- valid, output, 1: one-cycle pulse when `count` updates.
- overflow, output, 1: last completed window saturated.
- busy, output, 1: 1 while in MEASURE.

Behaviour:
- Reset values: count=0, valid=0, overflow=0, busy=0; state=IDLE; all internal counters 0; synchronizer flops 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then an edge register.
  - edge_pulse = sync & ~sync_d (one cycle per rising edge).
  - Latency from a sig_in rising edge to edge_pulse is 2-3 clk cycles.
- IDLE state:
  - gate_cnt=0, edge_cnt=0, busy=0.
  - count and overflow hold their last values.
  - en=1 → MEASURE next cycle. An edge_pulse in the transition cycle is not counted.
- MEASURE state (busy=1):
  - gate_cnt increments each cycle, from 0 to GATE_CYCLES-1.
  - edge_cnt += edge_pulse, saturating at 2^CW-1. Saturation sets an internal sat flag.
- Terminal cycle (gate_cnt == GATE_CYCLES-1):
  - count <= edge_cnt + edge_pulse (saturating). An edge on the terminal cycle belongs to this window.
  - overflow <= sat, or the addition saturates.
  - valid = 1 on the following cycle only.
  - gate_cnt, edge_cnt and sat clear to 0. The next window starts immediately with no dead cycle.
  - An edge on the first cycle of the next window counts in the next window.
- en falls mid-window: return to IDLE next cycle. The partial window is discarded: no valid, count and overflow unchanged.
- en falls on the terminal cycle: that window still completes and valid fires.
- Reset mid-window: all state clears immediately. No valid for the interrupted window.
- valid is registered. count and overflow change only in the same cycle valid is asserted.
- A sig_in frequency above clk/2 cannot be measured. The sync/edge path yields at most one edge per 2 cycles.

Optional Feature:
- Macro: FREQ_METER_PERIOD_MEAS_EN.
- Defined: adds outputs `period[PW-1:0]` and `period_valid`.
  - A per-cycle counter, saturating at 2^PW-1, measures clk cycles between consecutive edge_pulses.
  - On each edge_pulse after the first since entering MEASURE: period <= counter value, period_valid pulses for 1 cycle, counter restarts at 1.
  - The first edge after reset or after en rises only arms the counter; no output.
  - The period logic is cleared in IDLE.
  - Reset values: period=0, period_valid=0.
- Undefined: these ports and their logic are absent. Frequency behaviour is identical.

Decomposition:
- Package freq_meter_pkg:
  - state enum {IDLE, MEASURE}.
  - Saturating-increment helper function.
  - Default constants for GATE_CYCLES and GW.
- Sub-module sync_edge_det:
  - 2-flop synchronizer plus rising-edge detector.
  - Ports: clk, reset, d, q, rise.
  - Reused for buttons elsewhere in the design.

Test Plan:
- GATE_CYCLES=100, CW=8, sig_in period 10 clk, en held 1 → valid every 100 cycles, count=10, overflow=0 for each window, any phase.
- GATE_CYCLES=100, CW=4, sig_in period 2 clk → count=15, overflow=1. Then sig_in period 20 → next full window count=5, overflow=0.
- en dropped at gate_cnt=50 → no valid, count holds its previous value, busy=0 the next cycle. en reasserted → first valid 100 cycles after MEASURE entry.
- Single sig_in edge timed so edge_pulse lands on gate_cnt=99 → count=1 in that window, 0 in the next. Edge landing on gate_cnt=0 → counted in the new window.
- reset pulsed at gate_cnt=70 → count=0, valid=0, busy=0 immediately. Measuring resumes from gate_cnt=0 after release with en=1.
- With FREQ_METER_PERIOD_MEAS_EN defined, sig_in period 37 clk → first edge gives no period_valid. Subsequent period_valid pulses 37 cycles apart with period=37.
